// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
// Imported by the per-bit debouncer and the top level.
package sw_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  localparam int DEF_TICK_DIV       = 50000;
  localparam int DEF_DEBOUNCE_TICKS = 10;
  localparam int CNT_W = $clog2(DEF_DEBOUNCE_TICKS + 1);

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce FSM,
// tick counter and the clean output flop.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic accept
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

  logic            s1_q;
  logic            s2_q;
  db_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            acc;

  // a bounce back to the clean level beats a pending tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    acc     = 1'b0;
    unique case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s2_q != clean_q) state_d = COUNTING;
      end
      COUNTING: begin
        if (s2_q == clean_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            acc     = 1'b1;
            clean_d = s2_q;
            cnt_d   = '0;
            state_d = STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean  = clean_q;
  assign accept = acc;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning: shared tick prescaler, per-bit
// debouncers, sticky change flags and summary irq.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             read_ack,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_change,
  output logic             irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    ps_q, ps_d;
  logic             tick;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic             irq_q, irq_d;

  // a fresh accept wins over a same-cycle read_ack
  always_comb begin
    tick  = (ps_q == PS_LAST);
    ps_d  = tick ? '0 : ps_q + PW'(1);
    chg_d = (read_ack ? '0 : chg_q) | accept;
    irq_d = |chg_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_q  <= '0;
      chg_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ps_q  <= ps_d;
      chg_q <= chg_d;
      irq_q <= irq_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .tick   (tick),
      .clean  (sw_clean[i]),
      .accept (accept[i])
    );
  end

  assign sw_change = chg_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench: stimulus queues expected output events,
// per-DUT monitors pop them whenever the outputs move.
module tb_sw_debounce;

  typedef struct {
    int          lo;
    int          hi;
    logic [15:0] cl;
    logic [15:0] ch;
    logic        ir;
    int          tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic        ack_a = 1'b0, ack_b = 1'b0;
  logic [15:0] sw_a = '0, sw_b = '0;
  logic [15:0] cl_a, ch_a, cl_b, ch_b;
  logic        irq_a, irq_b;
  logic        mon_a = 1'b0, mon_b = 1'b0;
  logic        snap_a = 1'b0, snap_b = 1'b0;
  logic [32:0] prev_a = '0, prev_b = '0;

  sw_debounce #(
    .WIDTH(16), .TICK_DIV(1), .DEBOUNCE_TICKS(4)
  ) dut_a (
    .clk(clk), .reset(rst_a), .sw_raw(sw_a),
    .read_ack(ack_a), .sw_clean(cl_a),
    .sw_change(ch_a), .irq(irq_a)
  );

  sw_debounce #(
    .WIDTH(16), .TICK_DIV(5), .DEBOUNCE_TICKS(3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .sw_raw(sw_b),
    .read_ack(ack_b), .sw_clean(cl_b),
    .sw_change(ch_b), .irq(irq_b)
  );

  function automatic string tname(input int t);
    case (t)
      0: return "a_reset";
      1: return "a_idle";
      2: return "a_step3";
      3: return "a_ack1";
      4: return "a_bounce";
      5: return "a_collide";
      6: return "a_ack2";
      7: return "a_fall";
      8: return "a_ack3";
      9: return "a_multi";
      10: return "b_reset";
      11: return "b_rise";
      12: return "b_midrst";
      13: return "b_quiet";
      default: return "unknown";
    endcase
  endfunction

  task automatic judge(input exp_t e, input logic [32:0] cur);
    checks++;
    if (cyc < e.lo || cyc > e.hi || cur !== {e.cl, e.ch, e.ir}) begin
      errors++;
      $display("FAIL %s: cyc=%0d clean=%h chg=%h irq=%b, want cyc %0d..%0d clean=%h chg=%h irq=%b",
               tname(e.tag), cyc, cur[32:17], cur[16:1], cur[0],
               e.lo, e.hi, e.cl, e.ch, e.ir);
    end
  endtask

  task automatic expire(input exp_t e);
    checks++;
    errors++;
    $display("FAIL %s: timeout at cyc=%0d, want event by cyc %0d",
             tname(e.tag), cyc, e.hi);
  endtask

  task automatic unexpected(input string dn, input logic [32:0] cur);
    checks++;
    errors++;
    $display("FAIL %s_unexpected: cyc=%0d clean=%h chg=%h irq=%b, want no change",
             dn, cyc, cur[32:17], cur[16:1], cur[0]);
  endtask

  always @(negedge clk) begin
    logic [32:0] cur;
    if (mon_a) begin
      cur = {cl_a, ch_a, irq_a};
      while (qa.size() > 0 && qa[0].hi < cyc) expire(qa.pop_front());
      if (cur !== prev_a || snap_a) begin
        if (qa.size() == 0) unexpected("a", cur);
        else judge(qa.pop_front(), cur);
      end
      prev_a = cur;
    end
  end

  always @(negedge clk) begin
    logic [32:0] cur;
    if (mon_b) begin
      cur = {cl_b, ch_b, irq_b};
      while (qb.size() > 0 && qb[0].hi < cyc) expire(qb.pop_front());
      if (cur !== prev_b || snap_b) begin
        if (qb.size() == 0) unexpected("b", cur);
        else judge(qb.pop_front(), cur);
      end
      prev_b = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit b, input int lo, input int hi,
                      input logic [15:0] cl, input logic [15:0] ch,
                      input logic ir, input int tag);
    exp_t e;
    e.lo  = cyc + lo;
    e.hi  = cyc + hi;
    e.cl  = cl;
    e.ch  = ch;
    e.ir  = ir;
    e.tag = tag;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  task automatic snap(input bit b, input logic [15:0] cl,
                      input logic [15:0] ch, input logic ir,
                      input int tag);
    push(b, 0, 0, cl, ch, ir, tag);
    if (b) snap_b = 1'b1;
    else   snap_a = 1'b1;
    tick(1);
    if (b) snap_b = 1'b0;
    else   snap_a = 1'b0;
  endtask

  task automatic pulse_ack_a(input logic [15:0] cl,
                             input logic [15:0] ch,
                             input logic ir, input int tag);
    ack_a = 1'b1;
    push(1'b0, 1, 1, cl, ch, ir, tag);
    tick(1);
    ack_a = 1'b0;
  endtask

  task automatic run_a();
    tick(1);
    mon_a = 1'b1;
    tick(2);
    snap(1'b0, 16'h0, 16'h0, 1'b0, 0);
    rst_a = 1'b1;
    tick(20);
    snap(1'b0, 16'h0, 16'h0, 1'b0, 1);
    sw_a = 16'h0008;
    push(1'b0, 7, 7, 16'h0008, 16'h0008, 1'b1, 2);
    tick(12);
    pulse_ack_a(16'h0008, 16'h0000, 1'b0, 3);
    tick(2);
    sw_a[0] = 1'b1;
    tick(2);
    sw_a[0] = 1'b0;
    tick(2);
    sw_a[0] = 1'b1;
    push(1'b0, 7, 7, 16'h0009, 16'h0001, 1'b1, 4);
    tick(12);
    sw_a[5] = 1'b1;
    tick(6);
    pulse_ack_a(16'h0029, 16'h0020, 1'b1, 5);
    tick(3);
    pulse_ack_a(16'h0029, 16'h0000, 1'b0, 6);
    tick(2);
    sw_a = 16'h0000;
    push(1'b0, 7, 7, 16'h0000, 16'h0029, 1'b1, 7);
    tick(12);
    pulse_ack_a(16'h0000, 16'h0000, 1'b0, 8);
    tick(2);
    sw_a = 16'hA5A5;
    push(1'b0, 7, 7, 16'hA5A5, 16'hA5A5, 1'b1, 9);
    tick(12);
  endtask

  task automatic run_b();
    tick(1);
    mon_b = 1'b1;
    tick(2);
    snap(1'b1, 16'h0, 16'h0, 1'b0, 10);
    rst_b = 1'b1;
    tick(3);
    sw_b = 16'h8000;
    push(1'b1, 14, 19, 16'h8000, 16'h8000, 1'b1, 11);
    tick(25);
    sw_b = 16'h0000;
    tick(7);
    rst_b = 1'b0;
    push(1'b1, 1, 1, 16'h0000, 16'h0000, 1'b0, 12);
    tick(1);
    rst_b = 1'b1;
    tick(30);
    snap(1'b1, 16'h0, 16'h0, 1'b0, 13);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: cyc=%0d, want bench done", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    tick(2);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL a_pending: left=%0d, want 0", qa.size());
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL b_pending: left=%0d, want 0", qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
